// File: rtl/sp_mem_arbiter_if.sv
// Bundle of requester, response and scratchpad-side signals shared by sp_mem_arbiter.
// slave modport is the arbiter's view; master is the clients'/memory's view.
interface sp_mem_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned TAG_W  = 10
);
  // Requester side; requester i occupies slice i of each packed vector.
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_bits_address;
  logic [NREQ-1:0]        req_bits_rw;
  logic [NREQ*DATA_W-1:0] req_bits_wData;
  logic [NREQ*TAG_W-1:0]  req_tag;

  logic [NREQ-1:0]        resp_valid;
  logic [NREQ-1:0]        resp_ready;
  logic [NREQ*DATA_W-1:0] resp_bits_rData;
  logic [NREQ*TAG_W-1:0]  resp_tag;

  // Scratchpad side.
  logic                   mem_valid;
  logic [ADDR_W-1:0]      mem_address;
  logic                   mem_rw;
  logic [DATA_W-1:0]      mem_wData;
  logic [DATA_W-1:0]      mem_rData;

  logic [31:0]            stat_conflicts;

  modport slave (
    input  req_valid, req_bits_address, req_bits_rw, req_bits_wData, req_tag,
    input  resp_ready, mem_rData,
    output req_ready, resp_valid, resp_bits_rData, resp_tag,
    output mem_valid, mem_address, mem_rw, mem_wData, stat_conflicts
  );

  modport master (
    output req_valid, req_bits_address, req_bits_rw, req_bits_wData, req_tag,
    output resp_ready, mem_rData,
    input  req_ready, resp_valid, resp_bits_rData, resp_tag,
    input  mem_valid, mem_address, mem_rw, mem_wData, stat_conflicts
  );
endinterface

// File: rtl/sp_mem_arbiter.sv
// Round-robin arbiter sharing one single-port scratchpad among NREQ requesters.
// Define SP_ARB_STATS_EN to build the saturating contention counter.
module sp_mem_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 1024,
  parameter int unsigned TAG_W  = 10
) (
  input logic              clk,
  input logic              reset,
  sp_mem_arbiter_if.slave  io
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  logic [NREQ-1:0]   eligible;
  logic [NREQ-1:0]   grant;
  logic              anyGrant;
  idx_t              grantIdx;
  idx_t              ptr;

  logic [ADDR_W-1:0] memAddress;
  logic              memRw;
  logic [DATA_W-1:0] memWData;
  logic [TAG_W-1:0]  grantTag;
  logic              readGrant;

  logic              inflightValid;
  idx_t              inflightId;
  logic [TAG_W-1:0]  inflightTag;

  logic [NREQ-1:0]   slotValid;
  logic [DATA_W-1:0] slotData [NREQ];
  logic [TAG_W-1:0]  slotTag  [NREQ];

  // Reads need an empty slot and no outstanding read; writes are always eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = io.req_valid[i] &&
                    (io.req_bits_rw[i] ||
                     (!slotValid[i] && !(inflightValid && (inflightId == idx_t'(i)))));
    end
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    idx_t cand;
    grant    = '0;
    grantIdx = ptr;
    anyGrant = 1'b0;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = idx_t'((32'(ptr) + k) % NREQ);
      if (!anyGrant && eligible[cand]) begin
        anyGrant = 1'b1;
        grantIdx = cand;
      end
    end
    if (anyGrant) begin
      grant[grantIdx] = 1'b1;
    end
  end

  always_comb begin
    memAddress = '0;
    memRw      = 1'b0;
    memWData   = '0;
    grantTag   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        memAddress = io.req_bits_address[i*ADDR_W +: ADDR_W];
        memRw      = io.req_bits_rw[i];
        memWData   = io.req_bits_wData[i*DATA_W +: DATA_W];
        grantTag   = io.req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  assign readGrant      = anyGrant && !memRw;

  assign io.req_ready   = grant;
  assign io.mem_valid   = anyGrant;
  assign io.mem_address = memAddress;
  assign io.mem_rw      = memRw;
  assign io.mem_wData   = memWData;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= idx_t'(NREQ - 1);
      inflightValid <= 1'b0;
      inflightId    <= '0;
      inflightTag   <= '0;
      slotValid     <= '0;
      for (int i = 0; i < NREQ; i++) begin
        slotData[i] <= '0;
        slotTag[i]  <= '0;
      end
    end else begin
      if (anyGrant) begin
        ptr <= grantIdx;
      end
      inflightValid <= readGrant;
      if (readGrant) begin
        inflightId  <= grantIdx;
        inflightTag <= grantTag;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (slotValid[i] && io.resp_ready[i]) begin
          slotValid[i] <= 1'b0;
        end
      end
      // Memory returns data the cycle after the strobe; the target slot is known empty.
      if (inflightValid) begin
        slotValid[inflightId] <= 1'b1;
        slotData[inflightId]  <= io.mem_rData;
        slotTag[inflightId]   <= inflightTag;
      end
    end
  end

  assign io.resp_valid = slotValid;

  for (genvar g = 0; g < NREQ; g++) begin : gen_resp
    assign io.resp_bits_rData[g*DATA_W +: DATA_W] = slotData[g];
    assign io.resp_tag[g*TAG_W +: TAG_W]          = slotTag[g];
  end

`ifdef SP_ARB_STATS_EN
  logic [31:0] conflicts;

  always_ff @(posedge clk) begin
    if (reset) begin
      conflicts <= '0;
    end else if (($countones(eligible) > 1) && (conflicts != '1)) begin
      conflicts <= conflicts + 32'd1;
    end
  end

  assign io.stat_conflicts = conflicts;
`else
  assign io.stat_conflicts = '0;
`endif

  a_grant_onehot : assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_grant_eligible : assert property (@(posedge clk) disable iff (reset)
    (grant & ~eligible) == '0);
  a_capture_free : assert property (@(posedge clk) disable iff (reset)
    inflightValid |-> !slotValid[inflightId]);

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed bench for sp_mem_arbiter: vector table for arbitration/slot flow plus
// hand-written read latency, backpressure, hazard and mid-flight reset sequences.
module tb_sp_mem_arbiter;
  localparam int unsigned NREQ   = 4;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 10;
  localparam int          NVEC   = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sp_mem_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  sp_mem_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  // Scratchpad model: write at the strobe edge, registered read data.
  logic [DATA_W-1:0] mem [1<<ADDR_W];
  logic [DATA_W-1:0] memRData;
  always @(posedge clk) begin
    if (bus.mem_valid) begin
      if (bus.mem_rw) mem[bus.mem_address] <= bus.mem_wData;
      else            memRData <= mem[bus.mem_address];
    end
  end
  assign bus.mem_rData = memRData;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    bus.req_valid[i]                         = v;
    bus.req_bits_rw[i]                       = w;
    bus.req_bits_address[i*ADDR_W +: ADDR_W] = a;
    bus.req_bits_wData[i*DATA_W +: DATA_W]   = d;
    bus.req_tag[i*TAG_W +: TAG_W]            = t;
  endtask

  task automatic idle();
    for (int i = 0; i < NREQ; i++) drive(i, 1'b0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [DATA_W-1:0] rdata(input int i);
    return bus.resp_bits_rData[i*DATA_W +: DATA_W];
  endfunction

  function automatic logic [TAG_W-1:0] rtag(input int i);
    return bus.resp_tag[i*TAG_W +: TAG_W];
  endfunction

  function automatic logic [DATA_W-1:0] pat(input int i);
    return {32'hD0D0_C0DE, 32'(i)};
  endfunction

  function automatic logic [31:0] expStat(input int unsigned n);
`ifdef SP_ARB_STATS_EN
    return 32'(n);
`else
    return 32'(n) & 32'd0;
`endif
  endfunction

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] rw;
    logic [NREQ-1:0] respReady;
    logic [NREQ-1:0] expReady;
    logic            expMemValid;
    logic [NREQ-1:0] expRespValid;
    int unsigned     stat;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] w, input logic [3:0] er,
                              input logic emv, input logic [3:0] erv, input int unsigned s);
    vec_t r;
    r.valid = v; r.rw = w; r.respReady = 4'b1111; r.expReady = er;
    r.expMemValid = emv; r.expRespValid = erv; r.stat = s;
    return r;
  endfunction

  initial begin
    logic [DATA_W-1:0] held;
    int gidx;

    vecs[0]  = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 0);
    vecs[1]  = mk(4'b1111, 4'b1111, 4'b0001, 1'b1, 4'b0000, 0);
    vecs[2]  = mk(4'b1111, 4'b1111, 4'b0010, 1'b1, 4'b0000, 1);
    vecs[3]  = mk(4'b1111, 4'b1111, 4'b0100, 1'b1, 4'b0000, 2);
    vecs[4]  = mk(4'b1111, 4'b1111, 4'b1000, 1'b1, 4'b0000, 3);
    vecs[5]  = mk(4'b1111, 4'b1111, 4'b0001, 1'b1, 4'b0000, 4);
    vecs[6]  = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 5);
    vecs[7]  = mk(4'b0011, 4'b0000, 4'b0010, 1'b1, 4'b0000, 5);
    vecs[8]  = mk(4'b0011, 4'b0000, 4'b0001, 1'b1, 4'b0000, 6);
    vecs[9]  = mk(4'b0011, 4'b0000, 4'b0000, 1'b0, 4'b0010, 6);
    vecs[10] = mk(4'b0011, 4'b0000, 4'b0010, 1'b1, 4'b0001, 6);
    vecs[11] = mk(4'b0011, 4'b0000, 4'b0001, 1'b1, 4'b0000, 6);
    vecs[12] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 6);
    vecs[13] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001, 6);
    vecs[14] = mk(4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 6);

    idle();
    bus.resp_ready = '0;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    check("rst.resp_valid", bus.resp_valid, 4'b0000);
    check("rst.mem_valid", bus.mem_valid, 1'b0);
    check("rst.stat", bus.stat_conflicts, 32'd0);
    check("rst.rdata0", rdata(0), 64'd0);

    // Table: requester i uses address 0x10+i, data pat(i), tag 0x100+i.
    for (int v = 0; v < NVEC; v++) begin
      for (int i = 0; i < NREQ; i++)
        drive(i, vecs[v].valid[i], vecs[v].rw[i], ADDR_W'(32'h10 + i), pat(i),
              TAG_W'(32'h100 + i));
      bus.resp_ready = vecs[v].respReady;
      #1;
      check($sformatf("vec%0d.ready", v), bus.req_ready, vecs[v].expReady);
      check($sformatf("vec%0d.mem_valid", v), bus.mem_valid, vecs[v].expMemValid);
      if (vecs[v].expMemValid) begin
        gidx = 0;
        for (int i = 0; i < NREQ; i++) if (vecs[v].expReady[i]) gidx = i;
        check($sformatf("vec%0d.mem_addr", v), bus.mem_address, 64'(32'h10 + gidx));
        check($sformatf("vec%0d.mem_rw", v), bus.mem_rw, vecs[v].rw[gidx]);
      end
      check($sformatf("vec%0d.resp_valid", v), bus.resp_valid, vecs[v].expRespValid);
      for (int i = 0; i < NREQ; i++) begin
        if (vecs[v].expRespValid[i]) begin
          check($sformatf("vec%0d.rdata%0d", v, i), rdata(i), pat(i));
          check($sformatf("vec%0d.tag%0d", v, i), rtag(i), 64'(32'h100 + i));
        end
      end
      check($sformatf("vec%0d.stat", v), bus.stat_conflicts, expStat(vecs[v].stat));
      tick();
    end

    // Single read: write at t, read at t+1, response visible at t+3.
    idle();
    bus.resp_ready = '0;
    drive(0, 1'b1, 1'b1, 10'd5, {8{8'hA5}}, '0);
    #1;
    check("sr.wr_ready", bus.req_ready, 4'b0001);
    check("sr.wr_rw", bus.mem_rw, 1'b1);
    check("sr.wr_addr", bus.mem_address, 64'd5);
    tick();
    drive(0, 1'b1, 1'b0, 10'd5, '0, 10'h3);
    #1;
    check("sr.rd_ready", bus.req_ready, 4'b0001);
    check("sr.rd_mem_valid", bus.mem_valid, 1'b1);
    check("sr.rd_rw", bus.mem_rw, 1'b0);
    tick();
    idle();
    #1;
    check("sr.t2_resp_valid", bus.resp_valid, 4'b0000);
    tick();
    check("sr.t3_resp_valid", bus.resp_valid, 4'b0001);
    check("sr.t3_rdata", rdata(0), {8{8'hA5}});
    check("sr.t3_tag", rtag(0), 64'h3);
    tick();
    check("sr.hold_valid", bus.resp_valid, 4'b0001);
    check("sr.hold_rdata", rdata(0), {8{8'hA5}});
    bus.resp_ready = 4'b0001;
    tick();
    check("sr.popped", bus.resp_valid, 4'b0000);

    // Backpressure: req1 read held un-popped, req2 writes keep flowing.
    bus.resp_ready = '0;
    drive(1, 1'b1, 1'b0, 10'd5, '0, 10'h7);
    drive(2, 1'b1, 1'b1, 10'h20, 64'h1234, '0);
    #1;
    check("bp.first_ready", bus.req_ready, 4'b0010);
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("bp.c%0d.ready", c), bus.req_ready, 4'b0100);
      if (c >= 2) begin
        check($sformatf("bp.c%0d.resp_valid", c), bus.resp_valid, 4'b0010);
        check($sformatf("bp.c%0d.rdata", c), rdata(1), {8{8'hA5}});
        check($sformatf("bp.c%0d.tag", c), rtag(1), 64'h7);
      end
    end
    held = rdata(1);
    idle();
    bus.resp_ready = 4'b0010;
    #1;
    check("bp.release_rdata", held, {8{8'hA5}});
    tick();
    check("bp.popped", bus.resp_valid, 4'b0000);

    // Read followed next cycle by a write to the same address: read sees old data.
    bus.resp_ready = '0;
    drive(0, 1'b1, 1'b1, 10'd7, 64'h11, '0);
    tick();
    drive(0, 1'b1, 1'b0, 10'd7, '0, 10'h55);
    #1;
    check("hz.rd_ready", bus.req_ready, 4'b0001);
    tick();
    idle();
    drive(1, 1'b1, 1'b1, 10'd7, 64'h22, '0);
    #1;
    check("hz.wr_ready", bus.req_ready, 4'b0010);
    tick();
    idle();
    tick();
    check("hz.resp_valid", bus.resp_valid, 4'b0001);
    check("hz.old_data", rdata(0), 64'h11);
    check("hz.tag", rtag(0), 64'h55);
    bus.resp_ready = 4'b0001;
    tick();
    drive(0, 1'b1, 1'b0, 10'd7, '0, 10'h56);
    #1;
    check("hz.rd2_ready", bus.req_ready, 4'b0001);
    tick();
    idle();
    tick();
    check("hz.new_data", rdata(0), 64'h22);
    check("hz.new_tag", rtag(0), 64'h56);
    tick();

    // Reset one cycle after a read grant drops the read and restores the pointer.
    bus.resp_ready = '0;
    drive(0, 1'b1, 1'b0, 10'd7, '0, 10'h99);
    #1;
    check("rs.rd_ready", bus.req_ready, 4'b0001);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rs.c%0d.resp_valid", c), bus.resp_valid, 4'b0000);
      check($sformatf("rs.c%0d.stat", c), bus.stat_conflicts, 32'd0);
      tick();
    end
    for (int i = 0; i < NREQ; i++) drive(i, 1'b1, 1'b1, ADDR_W'(32'h30 + i), pat(i), '0);
    #1;
    check("rs.first_grant", bus.req_ready, 4'b0001);
    tick();
    check("rs.second_grant", bus.req_ready, 4'b0010);
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sp_mem_arbiter.md
# sp_mem_arbiter

Round-robin arbiter that shares one single-port scratchpad memory (1-cycle registered read, always ready, write on `valid && rw==1`, read on `valid && rw==0`) among NREQ requesters. Each requester gets a decoupled request port and a decoupled, tagged response port. Read data is routed back to the issuing requester through a per-requester one-entry response slot. The block sits between the engine-side memory clients and the scratchpad instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 10, memory address width
- DATA_W, 1024, memory data width
- TAG_W, 10, request/response tag width

Ports (requester i occupies slice i of every packed vector):
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- io_req_valid  in  NREQ  request valid per requester
- io_req_ready  out  NREQ  request accepted (one-hot or zero)
- io_req_bits_address  in  NREQ*ADDR_W  word address
- io_req_bits_rw  in  NREQ  1 = write, 0 = read
- io_req_bits_wData  in  NREQ*DATA_W  write data
- io_req_tag  in  NREQ*TAG_W  tag returned with read response
- io_resp_valid  out  NREQ  response slot full
- io_resp_ready  in  NREQ  requester consumes response
- io_resp_bits_rData  out  NREQ*DATA_W  read data per slot
- io_resp_tag  out  NREQ*TAG_W  tag per slot
- io_mem_valid  out  1  memory access strobe
- io_mem_address  out  ADDR_W  memory address
- io_mem_rw  out  1  memory write enable
- io_mem_wData  out  DATA_W  memory write data
- io_mem_rData  in  DATA_W  memory read data, valid one cycle after read strobe
- io_stat_conflicts  out  32  contention counter (see Configuration)

## Operation
- Eligibility: requester i eligible when io_req_valid[i] and (rw==1, or (slot i empty and no read in flight for i)). Writes need no slot.
- Grant: at most one eligible requester per cycle, chosen round-robin starting at ptr+1 mod NREQ. io_req_ready = grant (combinational from valid; no ready-to-valid dependency on the requester side). ptr <= granted index on grant; unchanged otherwise.
- Memory drive: io_mem_valid = |grant; address/rw/wData muxed from granted requester; all zeros when no grant.
- Read in flight: on read grant, register inflight_valid=1, inflight_id=i, inflight_tag=tag. Next cycle capture io_mem_rData and inflight_tag into slot inflight_id; set slot valid.
- Slot pop: slot i cleared on io_resp_valid[i] && io_resp_ready[i]. Eligibility uses registered slot state only (no same-cycle pop bypass).
- Writes produce no response.

## Timing
- Reset: ptr = NREQ-1 (requester 0 first), inflight_valid=0, all slots empty; io_resp_valid=0, io_mem_valid=0 while no request, io_stat_conflicts=0. rData/tag outputs undefined-but-stable (cleared to 0).
- Read latency: accept cycle t; io_mem_valid in t; slot valid from t+2.
- Same-requester read-to-read: minimum 3 cycles (t, pop at t+2, re-eligible t+3). Different requesters: one access per cycle.
- Writes: one per cycle, memory updated at end of accept cycle.
- Read followed next cycle by write to same address from another requester: read returns old data.
- Reset asserted mid-read: in-flight read dropped, no response produced.
- Response held stable while io_resp_valid && !io_resp_ready.

## Configuration
- SP_ARB_STATS_EN defined: io_stat_conflicts increments (saturating at 2^32-1) each cycle with more than one eligible requester; cleared by reset.
- Undefined: counter logic absent; io_stat_conflicts tied to 0.

## Test plan
- Single read: req 0 writes 0xA5.. to addr 5, then reads addr 5 tag 0x3 -> io_mem_valid cycles t,t+1 (write, read); io_resp_valid[0] at t+3 with rData 0xA5.., tag 0x3.
- Round robin: all 4 requesters hold write valid after reset -> grants 0,1,2,3,0 on consecutive cycles; conflicts counter = 5 with SP_ARB_STATS_EN, 0 without.
- Backpressure: req 1 reads, io_resp_ready[1]=0 for 10 cycles -> slot held stable, req 1 further reads not granted, req 2 writes still granted each cycle.
- Read-then-write hazard: req 0 reads addr 7 (old 0x11) at t, req 1 writes 0x22 to addr 7 at t+1 -> req 0 response 0x11; later read returns 0x22.
- Reset mid-flight: reset asserted in cycle after read grant -> no io_resp_valid after reset, ptr restarts so req 0 wins first contention.
